// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter slice.
// bin2gray is also used by reference models, so it takes the widest legal value.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 3;
  localparam int GRAY_MAX_WIDTH     = 16;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] value
  );
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Combinational binary to reflected Gray code conversion.
module gray_bin2gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Enable-gated Gray-code counter with a sticky wrap flag.
// Counts in binary; the output is decoded from registered state only, so it never depends on En.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_cnt;
  logic             ovf;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_cnt <= '0;
      ovf     <= 1'b0;
    end else if (En) begin
      if (bin_cnt == CNT_MAX) begin
        bin_cnt <= '0;
        ovf     <= 1'b1;
      end else begin
        bin_cnt <= bin_cnt + CNT_ONE;
      end
    end
  end

  gray_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_cnt),
    .gray (Output)
  );

  assign Overflow = ovf;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: a WIDTH=3 instance for the main plan and a WIDTH=4 instance.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] gray3;
  logic       ovf3;

  logic       rst4_n;
  logic       en4;
  logic [3:0] gray4;
  logic       ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] seq3 [8];

  gray_counter #(.WIDTH(3)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .En       (en),
    .Output   (gray3),
    .Overflow (ovf3)
  );

  gray_counter #(.WIDTH(4)) dut4 (
    .Clk      (clk),
    .Reset    (rst4_n),
    .En       (en4),
    .Output   (gray4),
    .Overflow (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples 1 ns after the rising edge; inputs are changed at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (gray3 !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_output cycle %0d: got %b expected 000", i, gray3);
      end
      n_checks++;
      if (ovf3 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_overflow cycle %0d: got %b expected 0", i, ovf3);
      end
    end
    en = 1'bx;
    tick();
    n_checks++;
    if (gray3 !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_x_en: got %b expected 000", gray3);
    end
    en = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gray3 !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_release_first_edge: got %b expected 001", gray3);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (gray3 !== seq3[i]) begin
        n_fail++;
        $display("FAIL sequence step %0d: got %b expected %b", i + 1, gray3, seq3[i]);
      end
      n_checks++;
      if (ovf3 !== (i == 7)) begin
        n_fail++;
        $display("FAIL sequence_overflow step %0d: got %b expected %b", i + 1, ovf3, (i == 7));
      end
    end
  endtask

  task automatic test_repeat();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (gray3 !== seq3[i] || ovf3 !== 1'b1) begin
        n_fail++;
        $display("FAIL repeat step %0d: got %b/%b expected %b/1", i + 1, gray3, ovf3, seq3[i]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (gray3 !== 3'b011) begin
      n_fail++;
      $display("FAIL hold_setup: got %b expected 011", gray3);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (gray3 !== 3'b011 || ovf3 !== 1'b0) begin
        n_fail++;
        $display("FAIL hold cycle %0d: got %b/%b expected 011/0", i, gray3, ovf3);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (gray3 !== 3'b010) begin
      n_fail++;
      $display("FAIL hold_resume: got %b expected 010", gray3);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (gray3 !== 3'b110 || ovf3 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: got %b/%b expected 110/1", gray3, ovf3);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gray3 !== 3'b000 || ovf3 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: got %b/%b expected 000/0", gray3, ovf3);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gray3 !== 3'b001 || ovf3 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_release: got %b/%b expected 001/0", gray3, ovf3);
    end
  endtask

  task automatic test_width4();
    logic [3:0] prev;
    rst4_n = 1'b0;
    #2;
    n_checks++;
    if (gray4 !== 4'b0000 || ovf4 !== 1'b0) begin
      n_fail++;
      $display("FAIL w4_reset: got %b/%b expected 0000/0", gray4, ovf4);
    end
    rst4_n = 1'b1;
    en4 = 1'b1;
    prev = 4'b0000;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++;
      if ($countones(prev ^ gray4) != 1) begin
        n_fail++;
        $display("FAIL w4_one_bit step %0d: got %b after %b expected one-bit change", i, gray4, prev);
      end
      n_checks++;
      if (ovf4 !== (i == 16)) begin
        n_fail++;
        $display("FAIL w4_overflow step %0d: got %b expected %b", i, ovf4, (i == 16));
      end
      if (i == 15) begin
        n_checks++;
        if (gray4 !== 4'b1000) begin
          n_fail++;
          $display("FAIL w4_step15: got %b expected 1000", gray4);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (gray4 !== 4'b0000) begin
          n_fail++;
          $display("FAIL w4_wrap: got %b expected 0000", gray4);
        end
      end
      prev = gray4;
    end
    en4 = 1'b0;
  endtask

  initial begin
    seq3[0] = 3'b001; seq3[1] = 3'b011; seq3[2] = 3'b010; seq3[3] = 3'b110;
    seq3[4] = 3'b111; seq3[5] = 3'b101; seq3[6] = 3'b100; seq3[7] = 3'b000;
    rst_n  = 1'b0;
    en     = 1'b0;
    rst4_n = 1'b0;
    en4    = 1'b0;
    #1;
    test_reset();
    test_sequence();
    test_repeat();
    test_hold();
    test_async_reset();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
